// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: raster sequencer for the video path.
// Steps horizontal and vertical FSMs on the pixel tick (vga_EN). It produces
// active-low syncs, blanking, pixel coordinates and a one-clock start-of-frame strobe.
// Optional build macro VGA_FRAME_CNT_EN adds the 8-bit frame counter output vga_FRAME.
module vga_timing_ctrl #(
  parameter int H_DISP = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_DISP = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33
) (
  input  logic                                                vga_CLK,
  input  logic                                                vga_RST,
  input  logic                                                vga_EN,
  output logic                                                vga_HS,
  output logic                                                vga_VS,
  output logic                                                vga_BLANK,
  output logic [$clog2(H_DISP+H_FP+H_SYNC+H_BP)-1:0]          vga_X,
  output logic [$clog2(V_DISP+V_FP+V_SYNC+V_BP)-1:0]          vga_Y,
  output logic                                                vga_SOF
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [7:0]                                          vga_FRAME
`endif
);

  // state  | meaning
  // -------+-----------------------------------------------
  // H_ACT  | visible pixels of the line
  // H_FP   | horizontal front porch
  // H_SYNC | horizontal sync pulse (vga_HS low)
  // H_BP   | horizontal back porch, last pixel wraps vga_X
  // V_ACT  | visible lines of the frame
  // V_FP   | vertical front porch
  // V_SYNC | vertical sync pulse (vga_VS low)
  // V_BP   | vertical back porch, last line wraps vga_Y

  localparam int H_TOT = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_DISP + V_FP + V_SYNC + V_BP;
  localparam int XW    = $clog2(H_TOT);
  localparam int YW    = $clog2(V_TOT);

  localparam logic [XW-1:0] H_DISP_M1 = XW'(H_DISP - 1);
  localparam logic [XW-1:0] H_FP_M1   = XW'(H_FP - 1);
  localparam logic [XW-1:0] H_SYNC_M1 = XW'(H_SYNC - 1);
  localparam logic [XW-1:0] H_BP_M1   = XW'(H_BP - 1);
  localparam logic [YW-1:0] V_DISP_M1 = YW'(V_DISP - 1);
  localparam logic [YW-1:0] V_FP_M1   = YW'(V_FP - 1);
  localparam logic [YW-1:0] V_SYNC_M1 = YW'(V_SYNC - 1);
  localparam logic [YW-1:0] V_BP_M1   = YW'(V_BP - 1);

  typedef enum logic [1:0] {H_ACT, H_FPO, H_SYN, H_BPO} h_state_t;
  typedef enum logic [1:0] {V_ACT, V_FPO, V_SYN, V_BPO} v_state_t;

  h_state_t      h_st, h_st_n;
  v_state_t      v_st, v_st_n;
  logic [XW-1:0] h_left, h_left_n, x_n;
  logic [YW-1:0] v_left, v_left_n, y_n;
  logic          line_end, frame_end;

  // Next-state decode: per-state down-counters reload on terminal count.
  always_comb begin
    h_st_n   = h_st;
    h_left_n = h_left - 1'b1;
    x_n      = vga_X + 1'b1;
    line_end = 1'b0;
    if (h_left == '0) begin
      case (h_st)
        H_ACT:   begin h_st_n = H_FPO; h_left_n = H_FP_M1;   end
        H_FPO:   begin h_st_n = H_SYN; h_left_n = H_SYNC_M1; end
        H_SYN:   begin h_st_n = H_BPO; h_left_n = H_BP_M1;   end
        default: begin
          h_st_n   = H_ACT;
          h_left_n = H_DISP_M1;
          x_n      = '0;
          line_end = 1'b1;
        end
      endcase
    end

    v_st_n    = v_st;
    v_left_n  = v_left;
    y_n       = vga_Y;
    frame_end = 1'b0;
    if (line_end) begin
      v_left_n = v_left - 1'b1;
      y_n      = vga_Y + 1'b1;
      if (v_left == '0) begin
        case (v_st)
          V_ACT:   begin v_st_n = V_FPO; v_left_n = V_FP_M1;   end
          V_FPO:   begin v_st_n = V_SYN; v_left_n = V_SYNC_M1; end
          V_SYN:   begin v_st_n = V_BPO; v_left_n = V_BP_M1;   end
          default: begin
            v_st_n    = V_ACT;
            v_left_n  = V_DISP_M1;
            y_n       = '0;
            frame_end = 1'b1;
          end
        endcase
      end
    end
  end

  // Raster FSMs with outputs registered from next-state so they track the counters.
  always_ff @(posedge vga_CLK) begin
    if (vga_RST) begin
      h_st      <= H_ACT;
      v_st      <= V_ACT;
      h_left    <= H_DISP_M1;
      v_left    <= V_DISP_M1;
      vga_X     <= '0;
      vga_Y     <= '0;
      vga_HS    <= 1'b1;
      vga_VS    <= 1'b1;
      vga_BLANK <= 1'b0;
      vga_SOF   <= 1'b0;
    end else if (vga_EN) begin
      h_st      <= h_st_n;
      v_st      <= v_st_n;
      h_left    <= h_left_n;
      v_left    <= v_left_n;
      vga_X     <= x_n;
      vga_Y     <= y_n;
      vga_HS    <= (h_st_n != H_SYN);
      vga_VS    <= (v_st_n != V_SYN);
      vga_BLANK <= !((h_st_n == H_ACT) && (v_st_n == V_ACT));
      vga_SOF   <= frame_end;
    end else begin
      vga_SOF   <= 1'b0;
    end
  end

`ifdef VGA_FRAME_CNT_EN
  // Frame counter steps in the same clock that vga_SOF rises.
  always_ff @(posedge vga_CLK) begin
    if (vga_RST)
      vga_FRAME <= '0;
    else if (vga_EN && frame_end)
      vga_FRAME <= vga_FRAME + 8'd1;
  end
`endif

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl with small raster: H 4/1/2/1 (8), V 3/1/1/1 (6).
module tb_vga_timing_ctrl;

  localparam int HD = 4, HF = 1, HS = 2, HB = 1;
  localparam int VD = 3, VF = 1, VS = 1, VB = 1;
  localparam int HT = HD + HF + HS + HB;
  localparam int VT = VD + VF + VS + VB;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en  = 1'b0;
  logic       hs_o, vs_o, blank_o, sof_o;
  logic [2:0] x_o;
  logic [2:0] y_o;
`ifdef VGA_FRAME_CNT_EN
  logic [7:0] frame_o;
`endif

  int total = 0;
  int bad   = 0;

  // reference model state: plain raster position
  int mx = 0, my = 0, msof = 0, mframe = 0;
  int sof_seen = 0;

  vga_timing_ctrl #(
    .H_DISP(HD), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_DISP(VD), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .vga_CLK  (clk),
    .vga_RST  (rst),
    .vga_EN   (en),
    .vga_HS   (hs_o),
    .vga_VS   (vs_o),
    .vga_BLANK(blank_o),
    .vga_X    (x_o),
    .vga_Y    (y_o),
    .vga_SOF  (sof_o)
`ifdef VGA_FRAME_CNT_EN
    ,
    .vga_FRAME(frame_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d (x=%0d y=%0d)", tag, obs, exp, mx, my);
    end
  endtask

  task automatic check_all();
    logic e_hs, e_vs, e_bl;
    e_hs = !(mx >= HD + HF && mx < HD + HF + HS);
    e_vs = !(my >= VD + VF && my < VD + VF + VS);
    e_bl = !(mx < HD && my < VD);
    chk("x",     {5'd0, x_o},     8'(mx));
    chk("y",     {5'd0, y_o},     8'(my));
    chk("hs",    {7'd0, hs_o},    {7'd0, e_hs});
    chk("vs",    {7'd0, vs_o},    {7'd0, e_vs});
    chk("blank", {7'd0, blank_o}, {7'd0, e_bl});
    chk("sof",   {7'd0, sof_o},   8'(msof));
`ifdef VGA_FRAME_CNT_EN
    chk("frame", frame_o,         8'(mframe));
`endif
  endtask

  // one clock with given inputs, then advance model and compare
  task automatic step(input logic e, input logic r);
    en  = e;
    rst = r;
    @(posedge clk);
    #1;
    if (r) begin
      mx = 0; my = 0; msof = 0; mframe = 0;
    end else if (e) begin
      msof = (mx == HT - 1 && my == VT - 1) ? 1 : 0;
      mx = (mx + 1) % HT;
      if (mx == 0) my = (my + 1) % VT;
      mframe = (mframe + msof) % 256;
    end else begin
      msof = 0;
    end
    if (sof_o === 1'b1) sof_seen++;
    check_all();
  endtask

  task automatic run_to(input int tx, input int ty);
    int n;
    n = 0;
    while (!(mx == tx && my == ty) && n < 200) begin
      step(1'b1, 1'b0);
      n++;
    end
    chk("reach_pos", 8'(n < 200), 8'd1);
  endtask

  initial begin
    // 1/2: reset then 48 constant-enable cycles, exactly one SOF at the end
    step(1'b0, 1'b1);
    chk("rst_sof", {7'd0, sof_o}, 8'd0);
    sof_seen = 0;
    for (int i = 0; i < 48; i++) step(1'b1, 1'b0);
    chk("sof_count_48", 8'(sof_seen), 8'd1);
    chk("sof_at_48", {7'd0, sof_o}, 8'd1);
    chk("wrap_x", {5'd0, x_o}, 8'd0);
    chk("wrap_y", {5'd0, y_o}, 8'd0);

    // 3: 50% duty enable across a frame wrap, SOF stays one clock
    sof_seen = 0;
    for (int i = 0; i < 2 * HT * VT; i++) step(1'(i % 2 == 0), 1'b0);
    chk("sof_count_half", 8'(sof_seen), 8'd1);

    // 4: freeze at X=5,Y=4
    run_to(5, 4);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
    chk("frz_hs", {7'd0, hs_o}, 8'd0);
    chk("frz_vs", {7'd0, vs_o}, 8'd0);
    step(1'b1, 1'b0);
    chk("resume_x", {5'd0, x_o}, 8'd6);

    // 5: mid-line reset at X=6,Y=2
    run_to(6, 2);
    step(1'b1, 1'b1);
    chk("rst_x", {5'd0, x_o}, 8'd0);
    chk("rst_hs", {7'd0, hs_o}, 8'd1);

    // random enable with occasional reset
    for (int i = 0; i < 600; i++)
      step(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 99) == 0));

`ifdef VGA_FRAME_CNT_EN
    // 6: 256 frames, counter wraps back to 0
    step(1'b0, 1'b1);
    for (int i = 0; i < 256 * HT * VT; i++) step(1'b1, 1'b0);
    chk("frame_wrap", frame_o, 8'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
